icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter INDEX_WIDTH, default 6, log2 of line count (64 one-word lines); tag width = 30-INDEX_WIDTH.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_inst_req  in  1  CPU-side sram-like request.
REQ-005 cpu_inst_wr  in  1  CPU-side write flag (uncached write path).
REQ-006 cpu_inst_size  in  2  transfer size, forwarded unchanged on the uncached path.
REQ-007 cpu_inst_addr  in  32  CPU byte address; [1:0] offset, [INDEX_WIDTH+1:2] index, [31:INDEX_WIDTH+2] tag.
REQ-008 cpu_inst_wdata  in  32  write data.
REQ-009 cpu_inst_rdata  out  32  read data, valid with cpu_inst_data_ok.
REQ-010 cpu_inst_addr_ok / cpu_inst_data_ok  out  1 each  CPU-side request accepted / response done.
REQ-011 cache_inst_req, cache_inst_wr  out  1 each; cache_inst_size out 2; cache_inst_addr, cache_inst_wdata out 32  memory-side sram-like request to the AXI interface.
REQ-012 cache_inst_rdata in 32; cache_inst_addr_ok, cache_inst_data_ok in 1 each  memory-side response.

Function
REQ-013 Storage: per line valid bit (flop), tag, 32-bit data; direct-mapped, one word per line.
REQ-014 FSM states IDLE, LOOKUP, MISS, REFILL; one outstanding CPU request maximum.
REQ-015 IDLE: cpu_inst_addr_ok = cpu_inst_req (combinational); on acceptance latch addr/wr/size/wdata, go LOOKUP; else stay.
REQ-016 LOOKUP, read, hit (valid & tag match): cpu_inst_data_ok=1, cpu_inst_rdata=line data this cycle, go IDLE; hit latency 1 cycle after addr_ok.
REQ-017 LOOKUP, read miss, or any write: go MISS; cpu_inst_data_ok=0.
REQ-018 MISS: cache_inst_req=1 with latched addr, wr, wdata; size=2'b10 for reads, latched size for writes; held until cache_inst_addr_ok=1, then go REFILL; cache_inst_req deasserts the following cycle.
REQ-019 REFILL: wait cache_inst_data_ok; on it, cpu_inst_data_ok=1, cpu_inst_rdata=cache_inst_rdata same cycle (combinational pass-through), go IDLE.
REQ-020 Read refill: on the data_ok cycle write tag, data, set valid for latched index (evicting any previous line).
REQ-021 Write: forwarded uncached; on the data_ok cycle clear valid of latched index if its tag matches; no allocation.
REQ-022 cpu_inst_addr_ok=0 in every state except IDLE; a CPU request held across LOOKUP/MISS/REFILL is accepted only on return to IDLE.
REQ-023 cache_inst_data_ok or cache_inst_addr_ok outside MISS/REFILL shall be ignored with no state change.
REQ-024 Simultaneous data_ok in REFILL and new cpu_inst_req: request not accepted that cycle; accepted next cycle in IDLE.

Reset
REQ-025 rst=1 at a clock edge: FSM to IDLE, all valid bits cleared, latched request discarded; tag/data arrays not cleared.
REQ-026 During and after reset cycle: cpu_inst_addr_ok=0 (while rst=1), cpu_inst_data_ok=0, cpu_inst_rdata=0, cache_inst_req=0, cache_inst_wr=0, cache_inst_size=0, cache_inst_addr=0, cache_inst_wdata=0.
REQ-027 Reset mid-MISS/REFILL abandons the transaction; late memory responses are ignored per REQ-023.

Configuration
REQ-028 Macro ICACHE_KSEG1_UNCACHED_EN defined: reads with addr[31:29]=3'b101 always take the MISS path, never hit, never allocate on refill.
REQ-029 Macro undefined: all addresses cacheable; kseg1 reads hit and allocate like any other.

Verification
REQ-030 After reset, read 0xBFC0_0000, memory returns 0x2408_0001 -> addr_ok cycle 0, cache_inst_req in MISS, cpu_inst_data_ok with 0x2408_0001 on memory data_ok cycle; with macro undefined, repeat read hits with data_ok 1 cycle after addr_ok, no cache_inst_req.
REQ-031 Same test with ICACHE_KSEG1_UNCACHED_EN defined -> repeat read of 0xBFC0_0000 issues a second cache_inst_req; line stays invalid.
REQ-032 Read 0x8000_0000 then 0x8000_0100 (same index, INDEX_WIDTH=6) then 0x8000_0000 -> three misses, third returns refetched data.
REQ-033 Refill line 0x8000_0040, then write 0x8000_0040 data 0xDEAD_BEEF size 2'b10 -> forwarded with cache_inst_wr=1; next read of 0x8000_0040 misses.
REQ-034 Assert rst during REFILL for 0x8000_0004, then memory data_ok -> no cpu_inst_data_ok, FSM IDLE, next read of 0x8000_0004 misses.

Source files
------------

// File: rtl/icache_dm_if.sv
// CPU-side and memory-side sram-like buses of the direct-mapped I-cache.
// slave = cache view, master = CPU/memory environment view.
interface icache_dm_if;
    logic        cpu_inst_req;
    logic        cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_wdata;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;

    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata;
    logic        cache_inst_addr_ok;
    logic        cache_inst_data_ok;

    modport slave (
        input  cpu_inst_req, cpu_inst_wr, cpu_inst_size,
        input  cpu_inst_addr, cpu_inst_wdata,
        output cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        output cache_inst_req, cache_inst_wr, cache_inst_size,
        output cache_inst_addr, cache_inst_wdata,
        input  cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
    );

    modport master (
        output cpu_inst_req, cpu_inst_wr, cpu_inst_size,
        output cpu_inst_addr, cpu_inst_wdata,
        input  cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        input  cache_inst_req, cache_inst_wr, cache_inst_size,
        input  cache_inst_addr, cache_inst_wdata,
        output cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache, uncached write path.
// Define ICACHE_KSEG1_UNCACHED_EN to make kseg1 reads bypass the cache.
module icache_dm #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    icache_dm_if.slave bus
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        REFILL
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wr;
    logic [1:0]  req_size;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   cacheable;
    logic                   tag_eq;
    logic                   hit;
    logic                   accept;
    logic                   fill_done;

    assign req_idx = req_addr[INDEX_WIDTH+1:2];
    assign req_tag = req_addr[31:INDEX_WIDTH+2];

`ifdef ICACHE_KSEG1_UNCACHED_EN
    assign cacheable = (req_addr[31:29] != 3'b101);
`else
    assign cacheable = 1'b1;
`endif

    assign tag_eq    = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit       = (state == LOOKUP) && !req_wr && cacheable && tag_eq;
    assign accept    = (state == IDLE) && bus.cpu_inst_req && !rst;
    assign fill_done = (state == REFILL) && bus.cache_inst_data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.cpu_inst_req) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = hit ? IDLE : MISS;
            MISS:    if (bus.cache_inst_addr_ok) state_nxt = REFILL;
            REFILL:  if (bus.cache_inst_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_wr    <= 1'b0;
            req_size  <= 2'b00;
        end else if (accept) begin
            req_addr  <= bus.cpu_inst_addr;
            req_wdata <= bus.cpu_inst_wdata;
            req_wr    <= bus.cpu_inst_wr;
            req_size  <= bus.cpu_inst_size;
        end
    end

    // Writes never allocate; they only drop a stale copy of the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_done) begin
            if (!req_wr && cacheable) begin
                valid[req_idx] <= 1'b1;
            end else if (req_wr && tag_eq) begin
                valid[req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_done && !req_wr && cacheable) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= bus.cache_inst_rdata;
        end
    end

    always_comb begin
        bus.cpu_inst_addr_ok = 1'b0;
        bus.cpu_inst_data_ok = 1'b0;
        bus.cpu_inst_rdata   = '0;
        bus.cache_inst_req   = 1'b0;
        bus.cache_inst_wr    = 1'b0;
        bus.cache_inst_size  = 2'b00;
        bus.cache_inst_addr  = '0;
        bus.cache_inst_wdata = '0;
        if (!rst) begin
            bus.cpu_inst_addr_ok = accept;
            unique case (1'b1)
                hit: begin
                    bus.cpu_inst_data_ok = 1'b1;
                    bus.cpu_inst_rdata   = data_mem[req_idx];
                end
                fill_done: begin
                    bus.cpu_inst_data_ok = 1'b1;
                    bus.cpu_inst_rdata   = bus.cache_inst_rdata;
                end
                default: ;
            endcase
            if (state == MISS) begin
                bus.cache_inst_req   = 1'b1;
                bus.cache_inst_wr    = req_wr;
                bus.cache_inst_size  = req_wr ? req_size : 2'b10;
                bus.cache_inst_addr  = req_addr;
                bus.cache_inst_wdata = req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm against a word-level memory/cache model.
// Honours ICACHE_KSEG1_UNCACHED_EN the same way the design does.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_dm_if bus();

    icache_dm #(.INDEX_WIDTH(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: backing memory by word address, and which word each slot holds.
    logic [31:0] mem_q [logic [29:0]];
    bit          ln_v [64];
    logic [29:0] ln_w [64];

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (mem_q.exists(w)) return mem_q[w];
        return {w, 2'b00} ^ 32'hA5A5_0F0F;
    endfunction

    function automatic bit cacheable(input logic [31:0] a);
`ifdef ICACHE_KSEG1_UNCACHED_EN
        return a[31:29] != 3'b101;
`else
        return 1'b1;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) ln_v[i] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_dok"}, bus.cpu_inst_data_ok, 0);
        check({tag, "_rdata"}, bus.cpu_inst_rdata, 0);
        check({tag, "_creq"}, bus.cache_inst_req, 0);
        check({tag, "_cwr"}, bus.cache_inst_wr, 0);
        check({tag, "_csize"}, bus.cache_inst_size, 0);
        check({tag, "_caddr"}, bus.cache_inst_addr, 0);
        check({tag, "_cwdata"}, bus.cache_inst_wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = 32'h8000_0000;
        #1;
        check("rst_aok", bus.cpu_inst_addr_ok, 0);
        @(posedge clk); #1;
        check("rst_aok2", bus.cpu_inst_addr_ok, 0);
        check_quiet("rst");
        rst = 1'b0;
        bus.cpu_inst_req = 1'b0;
        clear_model();
        #1;
        check_quiet("post_rst");
    endtask

    // Starts and ends just after a rising edge with the cache idle.
    task automatic access(input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit hold);
        logic [29:0] w;
        int          idx;
        bit          hit;
        logic [31:0] exp;
        logic [31:0] rd;
        w   = addr[31:2];
        idx = int'(w[5:0]);
        hit = !wr && ln_v[idx] && (ln_w[idx] == w);
        exp = mem_rd(w);
        bus.cpu_inst_req   = 1'b1;
        bus.cpu_inst_wr    = wr;
        bus.cpu_inst_size  = size;
        bus.cpu_inst_addr  = addr;
        bus.cpu_inst_wdata = wdata;
        #1;
        check("acc_aok", bus.cpu_inst_addr_ok, 1);
        @(posedge clk); #1;
        bus.cpu_inst_req = hold;
        if (hold) begin
            bus.cpu_inst_addr  = $urandom;
            bus.cpu_inst_wr    = 1'($urandom);
            bus.cpu_inst_wdata = $urandom;
        end
        #1;
        check("lk_aok", bus.cpu_inst_addr_ok, 0);
        if (hit) begin
            check("hit_dok", bus.cpu_inst_data_ok, 1);
            check("hit_data", bus.cpu_inst_rdata, exp);
            check("hit_creq", bus.cache_inst_req, 0);
            @(posedge clk); #1;
        end else begin
            check("miss_dok", bus.cpu_inst_data_ok, 0);
            @(posedge clk); #1;
            repeat ($urandom_range(0, 3)) begin
                check("miss_hold", bus.cache_inst_req, 1);
                @(posedge clk); #1;
            end
            check("miss_creq", bus.cache_inst_req, 1);
            check("miss_cwr", bus.cache_inst_wr, wr);
            check("miss_csize", bus.cache_inst_size, wr ? size : 2'b10);
            check("miss_caddr", bus.cache_inst_addr, addr);
            if (wr) check("miss_cwdata", bus.cache_inst_wdata, wdata);
            check("miss_aok", bus.cpu_inst_addr_ok, 0);
            bus.cache_inst_addr_ok = 1'b1;
            @(posedge clk); #1;
            bus.cache_inst_addr_ok = 1'b0;
            #1;
            check("refill_creq", bus.cache_inst_req, 0);
            repeat ($urandom_range(0, 3)) begin
                check("refill_wait", bus.cpu_inst_data_ok, 0);
                @(posedge clk); #1;
            end
            rd = wr ? 32'($urandom) : exp;
            bus.cache_inst_data_ok = 1'b1;
            bus.cache_inst_rdata   = rd;
            #1;
            check("fill_dok", bus.cpu_inst_data_ok, 1);
            check("fill_data", bus.cpu_inst_rdata, rd);
            check("fill_aok", bus.cpu_inst_addr_ok, 0);
            @(posedge clk); #1;
            bus.cache_inst_data_ok = 1'b0;
            bus.cache_inst_rdata   = '0;
            if (wr) begin
                if (ln_v[idx] && ln_w[idx] == w) ln_v[idx] = 1'b0;
                if (size == 2'b10) mem_q[w] = wdata;
            end else if (cacheable(addr)) begin
                ln_v[idx] = 1'b1;
                ln_w[idx] = w;
            end
        end
        bus.cpu_inst_req = 1'b0;
    endtask

    // Stray memory responses while idle must be ignored.
    task automatic noise();
        bus.cache_inst_addr_ok = 1'($urandom);
        bus.cache_inst_data_ok = 1'b1;
        bus.cache_inst_rdata   = $urandom;
        #1;
        check("noise_dok", bus.cpu_inst_data_ok, 0);
        check("noise_creq", bus.cache_inst_req, 0);
        @(posedge clk); #1;
        bus.cache_inst_addr_ok = 1'b0;
        bus.cache_inst_data_ok = 1'b0;
        bus.cache_inst_rdata   = '0;
    endtask

    logic [31:0] bases [4];

    initial begin
        bus.cpu_inst_req       = 1'b0;
        bus.cpu_inst_wr        = 1'b0;
        bus.cpu_inst_size      = 2'b10;
        bus.cpu_inst_addr      = '0;
        bus.cpu_inst_wdata     = '0;
        bus.cache_inst_rdata   = '0;
        bus.cache_inst_addr_ok = 1'b0;
        bus.cache_inst_data_ok = 1'b0;
        rst = 1'b1;
        mem_q[30'h2FF0_0000] = 32'h2408_0001;
        clear_model();
        @(posedge clk); #1;
        do_reset();

        access(1'b0, 2'b10, 32'hBFC0_0000, '0, 1'b0);
        access(1'b0, 2'b10, 32'hBFC0_0000, '0, 1'b0);

        access(1'b0, 2'b10, 32'h8000_0000, '0, 1'b0);
        access(1'b0, 2'b10, 32'h8000_0100, '0, 1'b0);
        access(1'b0, 2'b10, 32'h8000_0000, '0, 1'b0);

        access(1'b0, 2'b10, 32'h8000_0040, '0, 1'b0);
        access(1'b0, 2'b10, 32'h8000_0040, '0, 1'b1);
        access(1'b1, 2'b10, 32'h8000_0040, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 2'b10, 32'h8000_0040, '0, 1'b0);
        access(1'b0, 2'b10, 32'h8000_0040, '0, 1'b0);

        noise();
        access(1'b0, 2'b00, 32'h8000_0040, '0, 1'b0);

        do_reset();
        access(1'b0, 2'b10, 32'h8000_0004, '0, 1'b0);
        do_reset();
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_wr   = 1'b0;
        bus.cpu_inst_addr = 32'h8000_0004;
        @(posedge clk); #1;
        bus.cpu_inst_req = 1'b0;
        @(posedge clk); #1;
        check("r34_creq", bus.cache_inst_req, 1);
        bus.cache_inst_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.cache_inst_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        check("r34_rst_dok", bus.cpu_inst_data_ok, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        bus.cache_inst_data_ok = 1'b1;
        bus.cache_inst_rdata   = 32'h1111_2222;
        #1;
        check("r34_late_dok", bus.cpu_inst_data_ok, 0);
        check("r34_late_rdata", bus.cpu_inst_rdata, 0);
        @(posedge clk); #1;
        bus.cache_inst_data_ok = 1'b0;
        bus.cache_inst_rdata   = '0;
        #1;
        check("r34_idle_creq", bus.cache_inst_req, 0);
        access(1'b0, 2'b10, 32'h8000_0004, '0, 1'b0);

        bases[0] = 32'h8000_0000;
        bases[1] = 32'h8000_0100;
        bases[2] = 32'hBFC0_0000;
        bases[3] = 32'h0040_0000;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic        wr;
            a  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 4);
            wr = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) noise();
            access(wr, 2'($urandom_range(0, 2)), a, $urandom,
                   1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
